// File: rtl/data_mem_arbiter.sv
// Two-master (scalar/vector) data memory arbiter with in-order response routing.
// Define DATA_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is vector-over-scalar priority.
module data_mem_arbiter #(
  parameter int MEM_W = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               s_req_i,
  input  logic               s_we_i,
  input  logic [31:0]        s_addr_i,
  input  logic [31:0]        s_wdata_i,
  input  logic [3:0]         s_be_i,
  output logic               s_gnt_o,
  output logic               s_rvalid_o,
  output logic               s_err_o,
  output logic [31:0]        s_rdata_o,
  input  logic               v_req_i,
  input  logic               v_we_i,
  input  logic [31:0]        v_addr_i,
  input  logic [31:0]        v_wdata_i,
  input  logic [3:0]         v_be_i,
  output logic               v_gnt_o,
  output logic               v_rvalid_o,
  output logic               v_err_o,
  output logic [31:0]        v_rdata_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [31:0]        mem_addr_o,
  output logic [MEM_W/8-1:0] mem_be_o,
  output logic [MEM_W-1:0]   mem_wdata_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic               mem_err_i,
  input  logic [MEM_W-1:0]   mem_rdata_i
);

  localparam int LANES = MEM_W / 32;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int BW    = MEM_W / 8;

  typedef enum logic [1:0] {ARB = 2'd0, HOLD_S = 2'd1, HOLD_V = 2'd2} hold_t;

  hold_t             state, state_nxt;
  logic              src_fifo  [DEPTH];
  logic [LW-1:0]     lane_fifo [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic              arb_v, sel_v, full, push, pop;
  logic              sel_we, head_v;
  logic [31:0]       sel_addr, sel_wdata, head_word;
  logic [3:0]        sel_be;
  logic [LW-1:0]     sel_lane, head_lane;
  logic [BW-1:0]     be_ext;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // On conflict, the master that did not win the last accepted transfer goes first.
`ifdef DATA_ARB_ROUND_ROBIN_EN
  logic last_v;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   last_v <= 1'b0;
    else if (push) last_v <= sel_v;
  end

  assign arb_v = v_req_i & (~s_req_i | ~last_v);
`else
  assign arb_v = v_req_i;
`endif

  assign full      = (cnt == CW'(DEPTH)) & ~mem_rvalid_i;
  assign mem_req_o = (s_req_i | v_req_i) & ~full & rst_ni;
  assign push      = mem_req_o & mem_gnt_i;
  assign pop       = mem_rvalid_i & (cnt != '0);
  assign s_gnt_o   = push & ~sel_v;
  assign v_gnt_o   = push & sel_v;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ARB;
    else         state <= state_nxt;
  end

  // A presented-but-stalled master stays selected until its grant arrives.
  always_comb begin
    state_nxt = ARB;
    sel_v     = arb_v;
    if (state == HOLD_S && s_req_i)      sel_v = 1'b0;
    else if (state == HOLD_V && v_req_i) sel_v = 1'b1;
    if (mem_req_o && !mem_gnt_i) state_nxt = sel_v ? HOLD_V : HOLD_S;
  end

  always_comb begin
    sel_addr    = sel_v ? v_addr_i  : s_addr_i;
    sel_wdata   = sel_v ? v_wdata_i : s_wdata_i;
    sel_be      = sel_v ? v_be_i    : s_be_i;
    sel_we      = sel_v ? v_we_i    : s_we_i;
    sel_lane    = '0;
    if (LANES > 1) sel_lane = sel_addr[2 +: LW];
    be_ext      = '0;
    be_ext[3:0] = sel_be;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      mem_addr_o  = sel_addr;
      mem_we_o    = sel_we;
      mem_be_o    = be_ext << {sel_lane, 2'b00};
      mem_wdata_o = {LANES{sel_wdata}};
    end
  end

  // Ordering FIFO: one entry per accepted transfer, retired by its rvalid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      src_fifo[wr_ptr]  <= sel_v;
      lane_fifo[wr_ptr] <= sel_lane;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_v     = src_fifo[rd_ptr];
  assign head_lane  = lane_fifo[rd_ptr];
  assign head_word  = mem_rdata_i[{head_lane, 5'd0} +: 32];
  assign s_rvalid_o = pop & ~head_v;
  assign v_rvalid_o = pop & head_v;
  assign s_err_o    = s_rvalid_o & mem_err_i;
  assign v_err_o    = v_rvalid_o & mem_err_i;
  assign s_rdata_o  = s_rvalid_o ? head_word : '0;
  assign v_rdata_o  = v_rvalid_o ? head_word : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized and directed bench for data_mem_arbiter (MEM_W=64, DEPTH=4) against a queue-based model.
module tb_data_mem_arbiter;
  localparam int MEM_W = 64;
  localparam int DEPTH = 4;
  localparam int NB    = MEM_W / 8;
  localparam int LANES = MEM_W / 32;

  logic clk = 1'b0;
  logic rst_n;
  logic s_req, s_we, v_req, v_we;
  logic [31:0] s_addr, s_wdata, v_addr, v_wdata;
  logic [3:0] s_be, v_be;
  logic s_gnt, s_rvalid, s_err, v_gnt, v_rvalid, v_err;
  logic [31:0] s_rdata, v_rdata;
  logic mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_addr;
  logic [NB-1:0] mem_be;
  logic [MEM_W-1:0] mem_wdata, mem_rdata;

  data_mem_arbiter #(.MEM_W(MEM_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_req_i(s_req), .s_we_i(s_we), .s_addr_i(s_addr), .s_wdata_i(s_wdata), .s_be_i(s_be),
    .s_gnt_o(s_gnt), .s_rvalid_o(s_rvalid), .s_err_o(s_err), .s_rdata_o(s_rdata),
    .v_req_i(v_req), .v_we_i(v_we), .v_addr_i(v_addr), .v_wdata_i(v_wdata), .v_be_i(v_be),
    .v_gnt_o(v_gnt), .v_rvalid_o(v_rvalid), .v_err_o(v_err), .v_rdata_o(v_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_err_i(mem_err), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: outstanding transfers as a queue; src 1 = vector.
  typedef struct {bit src; int lane;} ent_t;
  ent_t q[$];
  bit lock_vld, lock_src, last_src;
  bit e_req, e_sg, e_vg, e_who, e_pop, e_we, e_srv, e_vrv, e_serr, e_verr;
  int e_lane;
  logic [31:0] e_addr, e_srd, e_vrd;
  logic [NB-1:0] e_be;
  logic [MEM_W-1:0] e_wd;

  task automatic model_eval();
    bit full;
    logic [31:0] a, wd;
    logic [3:0] be;
    logic [MEM_W-1:0] sh;
    ent_t h;
    if (!rst_n) begin
      q.delete();
      lock_vld = 0;
      last_src = 0;
    end
    full  = (q.size() == DEPTH) && !mem_rvalid;
    e_req = (s_req || v_req) && !full && rst_n;
    if (lock_vld && (lock_src ? v_req : s_req)) e_who = lock_src;
    else if (s_req && v_req) begin
`ifdef DATA_ARB_ROUND_ROBIN_EN
      e_who = !last_src;
`else
      e_who = 1'b1;
`endif
    end else e_who = v_req;
    a  = e_who ? v_addr : s_addr;
    wd = e_who ? v_wdata : s_wdata;
    be = e_who ? v_be : s_be;
    e_lane = int'((a >> 2) % LANES);
    e_addr = 0; e_we = 0; e_be = 0; e_wd = 0;
    if (e_req) begin
      e_addr = a;
      e_we   = e_who ? v_we : s_we;
      e_be   = NB'(be) << (4 * e_lane);
      for (int i = 0; i < LANES; i++) e_wd[32*i +: 32] = wd;
    end
    e_sg  = e_req && mem_gnt && !e_who;
    e_vg  = e_req && mem_gnt && e_who;
    e_pop = mem_rvalid && (q.size() > 0);
    e_srv = 0; e_vrv = 0; e_serr = 0; e_verr = 0; e_srd = 0; e_vrd = 0;
    if (e_pop) begin
      h  = q[0];
      sh = mem_rdata >> (32 * h.lane);
      if (h.src) begin e_vrv = 1; e_verr = mem_err; e_vrd = sh[31:0]; end
      else       begin e_srv = 1; e_serr = mem_err; e_srd = sh[31:0]; end
    end
  endtask

  task automatic model_update();
    if (!rst_n) return;
    if (e_pop) void'(q.pop_front());
    if (e_req && mem_gnt) begin
      q.push_back('{e_who, e_lane});
      last_src = e_who;
    end
    lock_vld = e_req && !mem_gnt;
    lock_src = e_who;
  endtask

  task automatic settle_check();
    #1;
    model_eval();
    check("mem_req", mem_req, e_req);
    check("gnt", {s_gnt, v_gnt}, {e_sg, e_vg});
    check("mem_addr", mem_addr, e_addr);
    check("mem_we", mem_we, e_we);
    check("mem_be", mem_be, e_be);
    check("mem_wdata", mem_wdata, e_wd);
    check("rsp", {s_rvalid, v_rvalid, s_err, v_err}, {e_srv, e_vrv, e_serr, e_verr});
    check("s_rdata", s_rdata, e_srd);
    check("v_rdata", v_rdata, e_vrd);
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    settle_check();
    edge_step();
  endtask

  task automatic idle();
    s_req = 0; s_we = 0; s_addr = 0; s_wdata = 0; s_be = 0;
    v_req = 0; v_we = 0; v_addr = 0; v_wdata = 0; v_be = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = 0;
  endtask

  task automatic drain(input int n);
    idle();
    mem_rvalid = 1;
    mem_rdata  = {$urandom, $urandom};
    for (int i = 0; i < n; i++) tick();
    idle();
  endtask

  bit [2:0] seq;
  bit s_hold, v_hold;

  initial begin
    idle();
    rst_n = 0;
    s_req = 1; v_req = 1; mem_gnt = 1; mem_rvalid = 1;
    settle_check();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_rsp", {s_gnt, v_gnt, s_rvalid, v_rvalid}, 4'b0);
    edge_step();
    tick();
    rst_n = 1;
    idle();
    tick();

    // Upper-lane read on a 64-bit port
    s_req = 1; s_addr = 32'h104; s_be = 4'hF; mem_gnt = 1;
    settle_check();
    check("be_0x104", mem_be, 8'hF0);
    edge_step();
    idle();
    mem_rvalid = 1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    settle_check();
    check("s_rdata_hi", s_rdata, 32'hAAAA_BBBB);
    check("s_rvalid_on", s_rvalid, 1'b1);
    edge_step();
    idle();
    settle_check();
    check("s_rvalid_off", s_rvalid, 1'b0);
    edge_step();

    // Conflict for three cycles
`ifdef DATA_ARB_ROUND_ROBIN_EN
    seq = 3'b101;
`else
    seq = 3'b111;
`endif
    for (int i = 0; i < 3; i++) begin
      s_req = 1; v_req = 1; s_addr = 32'h10; v_addr = 32'h24; mem_gnt = 1;
      settle_check();
      check("conflict_v_gnt", v_gnt, seq[2-i]);
      check("conflict_s_gnt", s_gnt, !seq[2-i]);
      edge_step();
    end
    drain(3);

    // Fill to DEPTH, then simultaneous pop and push
    for (int i = 0; i < DEPTH; i++) begin
      s_req = 1; s_addr = 32'h200 + 4 * i; mem_gnt = 1;
      tick();
    end
    settle_check();
    check("full_req_low", mem_req, 1'b0);
    edge_step();
    mem_rvalid = 1;
    settle_check();
    check("full_pop_push_gnt", s_gnt, 1'b1);
    edge_step();
    mem_rvalid = 0;
    settle_check();
    check("still_full", mem_req, 1'b0);
    edge_step();
    drain(DEPTH);

    // Response routing and error gating
    v_req = 1; v_we = 0; v_addr = 32'h300; mem_gnt = 1;
    tick();
    idle();
    s_req = 1; s_we = 1; s_addr = 32'h304; s_wdata = 32'h1234_5678; s_be = 4'h3; mem_gnt = 1;
    tick();
    idle();
    mem_rvalid = 1;
    settle_check();
    check("route_first_v", {v_rvalid, s_rvalid}, 2'b10);
    edge_step();
    mem_rvalid = 1; mem_err = 1;
    settle_check();
    check("route_second_s", {v_rvalid, s_rvalid}, 2'b01);
    check("err_s_only", {s_err, v_err}, 2'b10);
    edge_step();
    idle();

    // Stalled scalar keeps the bus against a later vector request
    s_req = 1; s_addr = 32'h400; mem_gnt = 0;
    tick();
    v_req = 1; v_addr = 32'h500;
    settle_check();
    check("hold_addr", mem_addr, 32'h400);
    edge_step();
    mem_gnt = 1;
    settle_check();
    check("hold_s_gnt", {s_gnt, v_gnt}, 2'b10);
    edge_step();
    s_req = 0;
    settle_check();
    check("after_hold_v_gnt", v_gnt, 1'b1);
    edge_step();
    drain(2);

    // Reset with outstanding transfers; stray rvalid afterwards
    s_req = 1; s_addr = 32'h600; mem_gnt = 1;
    tick(); tick();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    mem_rvalid = 1;
    settle_check();
    check("stray_rvalid", {s_rvalid, v_rvalid}, 2'b00);
    edge_step();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      s_req = 1; s_addr = 32'h700; mem_gnt = 1;
      settle_check();
      check("post_rst_room", s_gnt, 1'b1);
      edge_step();
    end
    drain(DEPTH);

    // Random traffic; held requests stay stable until granted
    s_hold = 0; v_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!s_hold) begin
        s_req = 1'($urandom_range(0, 1)); s_we = 1'($urandom_range(0, 1));
        s_addr = $urandom; s_wdata = $urandom; s_be = 4'($urandom_range(0, 15));
      end
      if (!v_hold) begin
        v_req = 1'($urandom_range(0, 1)); v_we = 1'($urandom_range(0, 1));
        v_addr = $urandom; v_wdata = $urandom; v_be = 4'($urandom_range(0, 15));
      end
      mem_gnt    = ($urandom_range(0, 9) < 6);
      mem_rvalid = ($urandom_range(0, 9) < 4);
      mem_err    = 1'($urandom_range(0, 1));
      mem_rdata  = {$urandom, $urandom};
      rst_n      = ($urandom_range(0, 499) != 0);
      tick();
      s_hold = s_req && !e_sg && rst_n;
      v_hold = v_req && !e_vg && rst_n;
    end
    rst_n = 1;
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
